// File: rtl/qsys_system_nios2_00_cpu_debug_host_pkg.sv
// Shared definitions for the Nios II debug host: FSM states and default geometry.
package qsys_system_nios2_00_cpu_debug_host_pkg;

   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;
   localparam int DEF_TCK_HALF = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RSP
   } state_e;

endpackage

// File: rtl/qsys_system_nios2_00_cpu_debug_host_tckgen.sv
// TCK generator: low phase then high phase of TCK_HALF clk cycles each, idle low.
module qsys_system_nios2_00_cpu_debug_host_tckgen
   import qsys_system_nios2_00_cpu_debug_host_pkg::*;
#(
   parameter int TCK_HALF = DEF_TCK_HALF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic tck_o,
   output logic fall_strobe_o,
   output logic rise_strobe_o
);

   localparam int CW = $clog2(2 * TCK_HALF);
   localparam logic [CW-1:0] HALF      = CW'(TCK_HALF);
   localparam logic [CW-1:0] HALF_LAST = CW'(TCK_HALF - 1);
   localparam logic [CW-1:0] LAST      = CW'(2 * TCK_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Strobes mark the clk edge at which tck rises or at which the period ends.
   assign rise_strobe_o = en_i && (cnt_q == HALF_LAST);
   assign fall_strobe_o = en_i && (cnt_q == LAST);
   assign tck_o         = (cnt_q >= HALF);

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || fall_strobe_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/qsys_system_nios2_00_cpu_debug_host.sv
// Debug host: turns one command into a UIR/CDR/SDR/UDR/RTI JTAG walk and returns captured tdo bits.
module qsys_system_nios2_00_cpu_debug_host
   import qsys_system_nios2_00_cpu_debug_host_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_HALF = DEF_TCK_HALF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic                tck,
   output logic                tdi,
   input  logic                tdo,
   output logic [IR_WIDTH-1:0] ir_in,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                jtag_state_rti
);

   localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

   state_e              state_q, state_d;
   logic [BW-1:0]       bitcnt_q, bitcnt_d;
   logic [IR_WIDTH-1:0] ir_q;
   logic [DR_WIDTH-1:0] sr_q;
   logic [DR_WIDTH-1:0] rsp_data_q;
   logic                rsp_valid_q;
   logic                tdi_q;
   logic                tck_en, fall_strobe, rise_strobe, accept;

   assign tck_en = (state_q != ST_IDLE) && (state_q != ST_RSP);
   assign accept = cmd_valid && cmd_ready;

   qsys_system_nios2_00_cpu_debug_host_tckgen #(
      .TCK_HALF(TCK_HALF)
   ) u_tckgen (
      .clk_i        (clk),
      .reset_i      (reset),
      .en_i         (tck_en),
      .tck_o        (tck),
      .fall_strobe_o(fall_strobe),
      .rise_strobe_o(rise_strobe)
   );

   assign cmd_ready      = (state_q == ST_IDLE) && !rsp_valid_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign tdi            = tdi_q;
   assign ir_in          = ir_q;
   assign vs_uir         = (state_q == ST_UIR);
   assign vs_cdr         = (state_q == ST_CDR);
   assign vs_sdr         = (state_q == ST_SDR);
   assign vs_udr         = (state_q == ST_UDR);
   assign jtag_state_rti = (state_q == ST_RTI);

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_UIR;
         ST_UIR:  if (fall_strobe) state_d = ST_CDR;
         ST_CDR: begin
            if (fall_strobe) begin
               state_d  = ST_SDR;
               bitcnt_d = '0;
            end
         end
         ST_SDR: begin
            if (fall_strobe) begin
               if (bitcnt_q == LAST_BIT) state_d = ST_UDR;
               else bitcnt_d = bitcnt_q + 1'b1;
            end
         end
         ST_UDR:  if (fall_strobe) state_d = ST_RTI;
         ST_RTI:  if (fall_strobe) state_d = ST_RSP;
         ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= '0;
         ir_q        <= '0;
         sr_q        <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         tdi_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         rsp_valid_q <= (state_d == ST_RSP);
         if (accept) begin
            ir_q <= cmd_ir;
            sr_q <= cmd_data;
         end else if ((state_q == ST_SDR) && rise_strobe) begin
            sr_q <= {tdo, sr_q[DR_WIDTH-1:1]};
         end
         // tdi moves only at period boundaries, so the slave sees it stable across the rising edge.
         if (fall_strobe) begin
            tdi_q <= (state_d == ST_SDR) && sr_q[0];
         end
         if ((state_q == ST_RTI) && fall_strobe) begin
            rsp_data_q <= sr_q;
         end
      end
   end

endmodule

// File: tb/tb_qsys_system_nios2_00_cpu_debug_host.sv
// Randomized self-checking bench with a cycle-level behavioural model of the debug host.
module tb_qsys_system_nios2_00_cpu_debug_host;

   localparam int DRW = 38;
   localparam int IRW = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           rsp_ready = 1'b0;
   logic [IRW-1:0] cmd_ir = '0;
   logic [DRW-1:0] cmd_data = '0;
   logic           tdo;
   logic           tdo_rnd = 1'b0;
   int             tdo_mode = 0;
   logic           sel = 1'b0;
   int             th = 2;

   logic           cv_a, cv_b, rr_a, rr_b;
   logic           cmd_ready_a, rsp_valid_a, tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a, rti_a;
   logic           cmd_ready_b, rsp_valid_b, tck_b, tdi_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;
   logic [DRW-1:0] rsp_data_a, rsp_data_b, o_rsp_data;
   logic [IRW-1:0] ir_a, ir_b, o_ir;
   logic [8:0]     ctl_a, ctl_b, o_ctl;

   assign cv_a = cmd_valid & ~sel;
   assign cv_b = cmd_valid & sel;
   assign rr_a = rsp_ready & ~sel;
   assign rr_b = rsp_ready & sel;

   qsys_system_nios2_00_cpu_debug_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(2)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cv_a), .cmd_ready(cmd_ready_a), .cmd_ir(cmd_ir),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid_a), .rsp_ready(rr_a), .rsp_data(rsp_data_a),
      .tck(tck_a), .tdi(tdi_a), .tdo(tdo), .ir_in(ir_a), .vs_uir(uir_a), .vs_cdr(cdr_a),
      .vs_sdr(sdr_a), .vs_udr(udr_a), .jtag_state_rti(rti_a));

   qsys_system_nios2_00_cpu_debug_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) dut_fast (
      .clk(clk), .reset(reset), .cmd_valid(cv_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid_b), .rsp_ready(rr_b), .rsp_data(rsp_data_b),
      .tck(tck_b), .tdi(tdi_b), .tdo(tdo), .ir_in(ir_b), .vs_uir(uir_b), .vs_cdr(cdr_b),
      .vs_sdr(sdr_b), .vs_udr(udr_b), .jtag_state_rti(rti_b));

   // ctl bits: ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti
   assign ctl_a = {cmd_ready_a, rsp_valid_a, tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a, rti_a};
   assign ctl_b = {cmd_ready_b, rsp_valid_b, tck_b, tdi_b, uir_b, cdr_b, sdr_b, udr_b, rti_b};
   assign o_ctl      = sel ? ctl_b : ctl_a;
   assign o_rsp_data = sel ? rsp_data_b : rsp_data_a;
   assign o_ir       = sel ? ir_b : ir_a;
   assign tdo = (tdo_mode == 0) ? o_ctl[5] : (tdo_mode == 1) ? 1'b1 : tdo_rnd;

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DRW-1:0] rnd_dr();
      return DRW'({$urandom(), $urandom()});
   endfunction

   // Model: 0 idle, 1 transaction (m_c = cycles since accept), 2 response pending.
   int             m_st = 0;
   int             m_c = 0;
   int             cyc = 0;
   int             acc_cyc = 0;
   int             rises = 0;
   logic           m_acc = 1'b0;
   logic           m_rst_chk = 1'b0;
   logic           prev_tck = 1'b0;
   logic [IRW-1:0] m_ir = '0;
   logic [DRW-1:0] m_data = '0, m_cap = '0, m_rsp = '0;

   always @(negedge clk) begin : model
      int p, w, tot;
      logic [8:0] e;
      cyc++;
      tot = (DRW + 4) * 2 * th;
      p = 0;
      w = 0;
      e = '0;
      case (m_st)
         0: e[8] = 1'b1;
         1: begin
            p = (m_c - 1) / (2 * th);
            w = (m_c - 1) % (2 * th);
            e[6] = (w >= th);
            e[4] = (p == 0);
            e[3] = (p == 1);
            e[2] = (p >= 2) && (p <= DRW + 1);
            e[1] = (p == DRW + 2);
            e[0] = (p == DRW + 3);
            if (e[2]) e[5] = m_data[p-2];
         end
         default: e[7] = 1'b1;
      endcase
      check_eq("ctl", 64'(o_ctl), 64'(e));
      check_eq("ir_in", 64'(o_ir), 64'(m_ir));
      if (m_st == 2) check_eq("rsp_data", 64'(o_rsp_data), 64'(m_rsp));
      if (m_rst_chk) check_eq("rsp_data_rst", 64'(o_rsp_data), 64'(0));
      if (o_ctl[6] && !prev_tck && o_ctl[2]) rises++;
      prev_tck = o_ctl[6];
      m_acc = 1'b0;
      m_rst_chk = 1'b0;
      if (reset) begin
         m_st = 0;
         m_ir = '0;
         m_rsp = '0;
         m_rst_chk = 1'b1;
      end else begin
         case (m_st)
            0: if (cmd_valid) begin
               m_st = 1;
               m_c = 1;
               m_ir = cmd_ir;
               m_data = cmd_data;
               m_cap = '0;
               m_acc = 1'b1;
               acc_cyc = cyc;
               rises = 0;
            end
            1: begin
               if (e[2] && (w == th - 1)) m_cap[p-2] = tdo;
               if (m_c == tot) begin
                  m_st = 2;
                  m_rsp = m_cap;
                  check_eq("sdr_periods", 64'(rises), 64'(DRW));
               end else begin
                  m_c++;
               end
            end
            default: if (rsp_ready) m_st = 0;
         endcase
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 tdo_rnd = 1'($urandom());
      end
   end

   task automatic wait_accept();
      int n = 0;
      bit ok = 0;
      while (n < 3000) begin
         @(posedge clk);
         n++;
         if (m_acc) begin
            ok = 1;
            break;
         end
      end
      #1 cmd_valid = 1'b0;
      cmd_data = rnd_dr();
      cmd_ir = IRW'($urandom());
      check_eq("accept_seen", 64'(ok), 64'(1));
   endtask

   task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] d);
      @(posedge clk);
      #1;
      cmd_ir = ir;
      cmd_data = d;
      cmd_valid = 1'b1;
      wait_accept();
   endtask

   task automatic wait_rsp(input int hold, output logic [DRW-1:0] data);
      int n = 0;
      bit ok = 0;
      while (n < 3000) begin
         @(negedge clk);
         #1;
         n++;
         if (o_ctl[7]) begin
            ok = 1;
            break;
         end
      end
      check_eq("rsp_seen", 64'(ok), 64'(1));
      if (ok) check_eq("rsp_lat", 64'(cyc - acc_cyc - 1), 64'((DRW + 4) * 2 * th));
      data = o_rsp_data;
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin : stim
      logic [DRW-1:0] d, got;
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1 check_eq("ready_after_rst", 64'(o_ctl[8]), 64'(1));

      // Loopback: response reproduces the shifted-out data.
      tdo_mode = 0;
      send(2'b01, 38'h2A_5555_AAAA);
      wait_rsp(0, got);
      check_eq("loop_data", 64'(got), 64'(38'h2A_5555_AAAA));

      // Constant tdo high.
      tdo_mode = 1;
      send(2'b01, rnd_dr());
      wait_rsp(0, got);
      check_eq("ones_data", 64'(got), 64'(38'h3F_FFFF_FFFF));
      check_eq("ir_hold", 64'(o_ir), 64'(2'b01));

      // Backpressure on the response.
      tdo_mode = 2;
      send(IRW'($urandom()), rnd_dr());
      wait_rsp(50, got);

      // Second command offered while busy and held through the response handshake.
      tdo_mode = 0;
      d = rnd_dr();
      send(2'b10, rnd_dr());
      repeat (60) @(negedge clk);
      @(posedge clk);
      #1;
      cmd_ir = 2'b11;
      cmd_data = d;
      cmd_valid = 1'b1;
      wait_rsp(0, got);
      wait_accept();
      wait_rsp(3, got);
      check_eq("second_data", 64'(got), 64'(d));

      // Reset during shift-DR bit 20, then a fresh transaction.
      send(2'b11, rnd_dr());
      n = 0;
      while (!(m_st == 1 && (m_c - 1) / (2 * th) == 22) && n < 1000) begin
         @(negedge clk);
         #1 n++;
      end
      check_eq("reached_bit20", 64'(n < 1000), 64'(1));
      do_reset();
      @(negedge clk);
      #1;
      check_eq("abort_tck", 64'(o_ctl[6]), 64'(0));
      check_eq("abort_sdr", 64'(o_ctl[2]), 64'(0));
      check_eq("abort_rsp", 64'(o_ctl[7]), 64'(0));
      d = rnd_dr();
      send(2'b01, d);
      wait_rsp(0, got);
      check_eq("post_abort_data", 64'(got), 64'(d));

      for (int i = 0; i < 4; i++) begin
         tdo_mode = int'($urandom_range(0, 2));
         send(IRW'($urandom()), rnd_dr());
         wait_rsp(int'($urandom_range(0, 5)), got);
      end

      // Fastest tck: the instance built with one clk per phase.
      @(posedge clk);
      #1;
      reset = 1'b1;
      sel = 1'b1;
      th = 1;
      @(posedge clk);
      #1 reset = 1'b0;
      tdo_mode = 0;
      send(2'b01, 38'h2A_5555_AAAA);
      wait_rsp(0, got);
      check_eq("fast_loop_data", 64'(got), 64'(38'h2A_5555_AAAA));
      for (int i = 0; i < 3; i++) begin
         tdo_mode = int'($urandom_range(0, 2));
         send(IRW'($urandom()), rnd_dr());
         wait_rsp(int'($urandom_range(0, 4)), got);
      end
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
